squashable_mult_pipe: RTL and testbench

Parametrised, branch-mask-aware pipelined integer multiplier for the EX stage. It executes RV32M MUL/MULH/MULHSU/MULHU over a configurable number of stages. It adds output backpressure, same-cycle squash of any in-flight entry whose branch mask hits a mispredicted branch, and clearing of branch-mask bits when a branch resolves correctly. It replaces the fixed-depth multiplier feeding `mul_packet_out` toward the CDB.

---
 rtl/squashable_mult_pipe.sv | 147 ++++++++++++++
 tb/tb_squashable_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/squashable_mult_pipe.sv
// Pipelined RV32M multiplier with global stall, branch-mask squash and resolve clearing.
// Each stage folds one multiplier chunk into a running 2*XLEN partial sum.
module squashable_mult_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned BMASK_W    = 8,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned ROB_W      = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_func,
  input  logic [XLEN-1:0]    in_rs1,
  input  logic [XLEN-1:0]    in_rs2,
  input  logic [TAG_W-1:0]   in_tag,
  input  logic [ROB_W-1:0]   in_rob_idx,
  input  logic [BMASK_W-1:0] in_bmask,
  input  logic               squash_valid,
  input  logic [BMASK_W-1:0] squash_bmask,
  input  logic               resolve_valid,
  input  logic [BMASK_W-1:0] resolve_bmask,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_data,
  output logic [TAG_W-1:0]   out_tag,
  output logic [ROB_W-1:0]   out_rob_idx,
  output logic [BMASK_W-1:0] out_bmask
);

  localparam int unsigned W2   = 2 * XLEN;
  localparam int unsigned C    = W2 / NUM_STAGES;
  localparam int unsigned LAST = NUM_STAGES - 1;

  logic [W2-1:0]      sum_q    [NUM_STAGES];
  logic [W2-1:0]      mcand_q  [NUM_STAGES];
  logic [W2-1:0]      mplier_q [NUM_STAGES];
  logic [1:0]         func_q   [NUM_STAGES];
  logic [TAG_W-1:0]   tag_q    [NUM_STAGES];
  logic [ROB_W-1:0]   rob_q    [NUM_STAGES];
  logic [BMASK_W-1:0] bmask_q  [NUM_STAGES];
  logic [NUM_STAGES-1:0] valid_q;

  logic [W2-1:0]      src_sum    [NUM_STAGES];
  logic [W2-1:0]      src_mcand  [NUM_STAGES];
  logic [W2-1:0]      src_mplier [NUM_STAGES];
  logic [1:0]         src_func   [NUM_STAGES];
  logic [TAG_W-1:0]   src_tag    [NUM_STAGES];
  logic [ROB_W-1:0]   src_rob    [NUM_STAGES];
  logic [BMASK_W-1:0] src_bmask  [NUM_STAGES];
  logic [NUM_STAGES-1:0] src_valid;
  logic [NUM_STAGES-1:0] src_kill;
  logic [NUM_STAGES-1:0] hold_kill;

  logic [W2-1:0]      d_sum    [NUM_STAGES];
  logic [W2-1:0]      d_mcand  [NUM_STAGES];
  logic [W2-1:0]      d_mplier [NUM_STAGES];

  logic [BMASK_W-1:0] res_mask_c;
  logic [W2-1:0]      in_mcand_c;
  logic [W2-1:0]      in_mplier_c;
  logic               advance_c;

  // Operand extension: rs1 unsigned only for MULHU, rs2 signed only for MUL/MULH
  always_comb begin
    res_mask_c  = resolve_valid ? resolve_bmask : '0;
    in_mcand_c  = (in_func == 2'b11) ? {{XLEN{1'b0}}, in_rs1}
                                     : {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
    in_mplier_c = in_func[1] ? {{XLEN{1'b0}}, in_rs2}
                             : {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
  end

  // Stage sources: stage 0 reads the issue port, stage k reads stage k-1
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (k == 0) begin
        src_sum[k]    = '0;
        src_mcand[k]  = in_mcand_c;
        src_mplier[k] = in_mplier_c;
        src_func[k]   = in_func;
        src_tag[k]    = in_tag;
        src_rob[k]    = in_rob_idx;
        src_bmask[k]  = in_bmask;
        src_valid[k]  = in_valid;
      end else begin
        src_sum[k]    = sum_q[k-1];
        src_mcand[k]  = mcand_q[k-1];
        src_mplier[k] = mplier_q[k-1];
        src_func[k]   = func_q[k-1];
        src_tag[k]    = tag_q[k-1];
        src_rob[k]    = rob_q[k-1];
        src_bmask[k]  = bmask_q[k-1];
        src_valid[k]  = valid_q[k-1];
      end
      src_kill[k]  = squash_valid & (|(src_bmask[k] & squash_bmask));
      hold_kill[k] = squash_valid & (|(bmask_q[k] & squash_bmask));
      d_sum[k]     = src_sum[k] + src_mcand[k] * W2'(src_mplier[k][C-1:0]);
      d_mcand[k]   = src_mcand[k] << C;
      d_mplier[k]  = src_mplier[k] >> C;
    end
  end

  // Head output; a squashed head reads as empty and frees the pipe this cycle
  always_comb begin
    out_valid   = valid_q[LAST] & ~hold_kill[LAST];
    out_data    = (func_q[LAST] == 2'b00) ? sum_q[LAST][XLEN-1:0] : sum_q[LAST][W2-1:XLEN];
    out_tag     = tag_q[LAST];
    out_rob_idx = rob_q[LAST];
    out_bmask   = bmask_q[LAST] & ~res_mask_c;
    advance_c   = ~out_valid | out_ready;
    in_ready    = advance_c;
  end

  // Global shift on advance; otherwise hold, dropping killed entries and resolved bits
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        sum_q[k]    <= '0;
        mcand_q[k]  <= '0;
        mplier_q[k] <= '0;
        func_q[k]   <= '0;
        tag_q[k]    <= '0;
        rob_q[k]    <= '0;
        bmask_q[k]  <= '0;
      end
    end else if (advance_c) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k]  <= src_valid[k] & ~src_kill[k];
        sum_q[k]    <= d_sum[k];
        mcand_q[k]  <= d_mcand[k];
        mplier_q[k] <= d_mplier[k];
        func_q[k]   <= src_func[k];
        tag_q[k]    <= src_tag[k];
        rob_q[k]    <= src_rob[k];
        bmask_q[k]  <= src_bmask[k] & ~res_mask_c;
      end
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        valid_q[k] <= valid_q[k] & ~hold_kill[k];
        bmask_q[k] <= bmask_q[k] & ~res_mask_c;
      end
    end
  end

endmodule

// File: tb/tb_squashable_mult_pipe.sv
// Directed self-checking bench for squashable_mult_pipe: latency, ordering,
// per-stage squash, stall/drain, resolve clearing, head kill and mid-flight reset.
module tb_squashable_mult_pipe;

  localparam int unsigned N = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_func;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [5:0]  in_tag;
  logic [4:0]  in_rob_idx;
  logic [7:0]  in_bmask;
  logic        squash_valid;
  logic [7:0]  squash_bmask;
  logic        resolve_valid;
  logic [7:0]  resolve_bmask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [5:0]  out_tag;
  logic [4:0]  out_rob_idx;
  logic [7:0]  out_bmask;

  int n_checks = 0;
  int n_pass   = 0;

  squashable_mult_pipe #(
    .XLEN(32), .NUM_STAGES(N), .BMASK_W(8), .TAG_W(6), .ROB_W(5)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
    .in_rob_idx(in_rob_idx), .in_bmask(in_bmask),
    .squash_valid(squash_valid), .squash_bmask(squash_bmask),
    .resolve_valid(resolve_valid), .resolve_bmask(resolve_bmask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_rob_idx(out_rob_idx), .out_bmask(out_bmask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_func       = 2'b00;
    in_rs1        = '0;
    in_rs2        = '0;
    in_tag        = '0;
    in_rob_idx    = '0;
    in_bmask      = '0;
    squash_valid  = 1'b0;
    squash_bmask  = '0;
    resolve_valid = 1'b0;
    resolve_bmask = '0;
  endtask

  task automatic issue(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t, input logic [4:0] r, input logic [7:0] m);
    in_valid   = 1'b1;
    in_func    = f;
    in_rs1     = a;
    in_rs2     = b;
    in_tag     = t;
    in_rob_idx = r;
    in_bmask   = m;
  endtask

  logic [1:0]  b2b_func [3];
  logic [31:0] b2b_rs1  [3];
  logic [31:0] b2b_rs2  [3];
  logic [31:0] b2b_exp  [3];
  int          seen;
  logic [31:0] got_data;

  initial begin
    b2b_func = '{2'b01, 2'b10, 2'b11};
    b2b_rs1  = '{32'hFFF0_0000, 32'hFFFF_8000, 32'hFFFF_FFFF};
    b2b_rs2  = '{32'hFFF0_0000, 32'd696969,    32'h0010_0000};
    b2b_exp  = '{32'h0000_0100, 32'hFFFF_FFFA, 32'h000F_FFFF};

    idle();
    out_ready = 1'b1;
    reset     = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_tag",   64'(out_tag),   64'd0);
    check("rst_out_rob",   64'(out_rob_idx), 64'd0);
    check("rst_out_bmask", 64'(out_bmask), 64'd0);

    // Single MUL, exact latency
    issue(2'b00, 32'd470, 32'd570, 6'h15, 5'h0A, 8'h80);
    settle();
    check("mul_in_ready", 64'(in_ready), 64'd1);
    tick();
    idle();
    for (int i = 0; i < int'(N) - 1; i++) begin
      settle();
      check("mul_early", 64'(out_valid), 64'd0);
      tick();
    end
    settle();
    check("mul_valid", 64'(out_valid),   64'd1);
    check("mul_data",  64'(out_data),    64'h0004_167C);
    check("mul_tag",   64'(out_tag),     64'h15);
    check("mul_rob",   64'(out_rob_idx), 64'h0A);
    check("mul_bmask", 64'(out_bmask),   64'h80);
    tick();
    settle();
    check("mul_gone", 64'(out_valid), 64'd0);

    // Back-to-back high-half variants
    for (int i = 0; i < 3; i++) begin
      issue(b2b_func[i], b2b_rs1[i], b2b_rs2[i], 6'(i + 1), 5'(i + 1), 8'h01);
      tick();
    end
    idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_data",  64'(out_data),  64'(b2b_exp[i]));
      check("b2b_tag",   64'(out_tag),   64'(i + 1));
      tick();
    end
    settle();
    check("b2b_gone", 64'(out_valid), 64'd0);

    // Squash at every stage: bit 7 hits mask F0, bit 3 misses it
    for (int s = 1; s <= int'(N); s++) begin
      for (int v = 0; v < 2; v++) begin
        issue(2'b11, 32'hFFFF_FFFF, 32'h0010_0000, 6'h2A, 5'h05, 8'hF0);
        tick();
        idle();
        for (int i = 0; i < s - 1; i++) tick();
        squash_valid = 1'b1;
        squash_bmask = (v == 1) ? 8'h08 : 8'h80;
        seen     = 0;
        got_data = '0;
        for (int c = 0; c <= int'(N); c++) begin
          settle();
          if (out_valid) begin
            seen++;
            got_data = out_data;
          end
          tick();
          squash_valid = 1'b0;
          squash_bmask = '0;
        end
        check("sq_seen", 64'(seen), (v == 1) ? 64'd1 : 64'd0);
        check("sq_data", 64'(got_data), (v == 1) ? 64'h000F_FFFF : 64'd0);
      end
    end

    // Full pipe, stall 3 cycles, then drain in order
    for (int k = 0; k < int'(N); k++) begin
      issue(2'b00, 32'(k + 1), 32'd100, 6'(10 + k), 5'(k), 8'h00);
      tick();
    end
    issue(2'b00, 32'd5, 32'd100, 6'd14, 5'd4, 8'h00);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("stall_in_ready", 64'(in_ready),  64'd0);
      check("stall_valid",    64'(out_valid), 64'd1);
      check("stall_tag",      64'(out_tag),   64'd10);
      check("stall_data",     64'(out_data),  64'd100);
      tick();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("drain_valid", 64'(out_valid), 64'd1);
      check("drain_tag",   64'(out_tag),   64'(10 + k));
      check("drain_data",  64'(out_data),  64'(100 * (k + 1)));
      tick();
      idle();
    end
    settle();
    check("drain_gone", 64'(out_valid), 64'd0);

    // Resolve clears bit 6 mid-pipe; squash on that bit then misses
    issue(2'b00, 32'd3, 32'd5, 6'd20, 5'd7, 8'hC0);
    tick();
    idle();
    tick();
    resolve_valid = 1'b1;
    resolve_bmask = 8'h40;
    tick();
    resolve_valid = 1'b0;
    resolve_bmask = '0;
    squash_valid  = 1'b1;
    squash_bmask  = 8'h40;
    tick();
    squash_valid  = 1'b0;
    squash_bmask  = '0;
    settle();
    check("res_valid", 64'(out_valid), 64'd1);
    check("res_bmask", 64'(out_bmask), 64'h80);
    check("res_data",  64'(out_data),  64'd15);

    // Stalled head killed by squash on its remaining bit; waiting entry then enters
    out_ready = 1'b0;
    issue(2'b00, 32'd7, 32'd6, 6'd21, 5'd8, 8'h00);
    tick();
    settle();
    check("hk_stall_valid", 64'(out_valid), 64'd1);
    check("hk_stall_ready", 64'(in_ready),  64'd0);
    squash_valid = 1'b1;
    squash_bmask = 8'h80;
    settle();
    check("hk_kill_valid", 64'(out_valid), 64'd0);
    check("hk_kill_ready", 64'(in_ready),  64'd1);
    tick();
    idle();
    out_ready = 1'b1;
    for (int i = 0; i < int'(N) - 1; i++) tick();
    settle();
    check("hk_next_valid", 64'(out_valid), 64'd1);
    check("hk_next_tag",   64'(out_tag),   64'd21);
    check("hk_next_data",  64'(out_data),  64'd42);
    tick();

    // Reset mid-flight discards the entry
    issue(2'b00, 32'd9, 32'd9, 6'd30, 5'd9, 8'h00);
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c <= int'(N); c++) begin
      settle();
      if (out_valid) seen++;
      tick();
    end
    check("rst_flush", 64'(seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
